// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID pipeline register.
// Owns the PC, addresses instruction memory combinationally from it, and
// latches the fetched word plus its PC for decode. Handles stall, redirect
// (branch/jump flush) and halts fetch on a misaligned redirect target.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic [6:0]  opcode_o,
    output logic        trap_o,
    output logic [31:0] trap_pc_o
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_TRAP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] trap_pc_q, trap_pc_d;

    logic        target_aligned;
    assign target_aligned = (redirect_pc_i[1:0] == 2'b00);

    // State and pipeline register update; reset overrides every other input.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            trap_pc_q     <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            trap_pc_q     <= trap_pc_d;
        end
    end

    // Next-state logic: redirect beats stall beats advance while running;
    // while trapped, only a redirect has any effect.
    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no
        // path through the case leaves a signal unassigned (no latches).
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        trap_pc_d     = trap_pc_q;

        case (state_q)
            S_RUN: begin
                if (redirect_i) begin
                    if_id_pc_d    = 32'h0000_0000;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                    if (target_aligned) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        trap_pc_d = redirect_pc_i;
                        state_d   = S_TRAP;
                    end
                end else if (!stall_i) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_data_i;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_q + 32'd4;  // wraps modulo 2^32
                end
            end
            S_TRAP: begin
                // Fetch is halted: keep the IF/ID register a bubble.
                if_id_pc_d    = 32'h0000_0000;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
                if (redirect_i) begin
                    if (target_aligned) begin
                        pc_d    = redirect_pc_i;
                        state_d = S_RUN;
                    end else begin
                        trap_pc_d = redirect_pc_i;
                    end
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    assign imem_addr_o   = pc_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_pc4_o   = if_id_pc_q + 32'd4;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_valid_o = if_id_valid_q;
    assign opcode_o      = if_id_instr_q[6:0];
    assign trap_o        = (state_q == S_TRAP);
    assign trap_pc_o     = trap_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Each cycle's expected post-edge state is
// computed by a small reference model when the inputs are driven, pushed to a
// queue, and popped and compared once the edge has happened.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        trap;
        logic [31:0] tpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [6:0]  opcode;
    logic        trap;
    logic [31:0] trap_pc;

    int n_checks = 0;
    int n_errors = 0;

    exp_t exp_q[$];
    exp_t m;  // reference model state (what the DUT should hold after the last edge)

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .redirect_i   (redir),
        .redirect_pc_i(redir_pc),
        .imem_addr_o  (imem_addr),
        .imem_data_i  (imem_data),
        .if_id_pc_o   (if_id_pc),
        .if_id_pc4_o  (if_id_pc4),
        .if_id_instr_o(if_id_instr),
        .if_id_valid_o(if_id_valid),
        .opcode_o     (opcode),
        .trap_o       (trap),
        .trap_pc_o    (trap_pc)
    );

    always #5 clk = ~clk;

    // Instruction memory image: low words are "addi x(k+1), x0, 5*(k+1)",
    // everything else is an address-derived R-type pattern.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        logic [11:0] imm;
        logic [4:0]  rd;
        if (a < 32'h40) begin
            imm = (a[13:2] + 12'd1) * 12'd5;
            rd  = a[6:2] + 5'd1;
            return {imm, 5'd0, 3'b000, rd, 7'b0010011};
        end
        return {a[31:7] ^ 25'h0F0_F0F0, 7'b0110011};
    endfunction

    assign imem_data = imem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model of one clock edge.
    function automatic exp_t model_next(input exp_t s, input logic r, input logic st,
                                        input logic rd, input logic [31:0] rpc);
        exp_t n = s;
        if (r) begin
            n = '{pc: RESET_PC, ipc: 32'h0, instr: NOP_INSTR, valid: 1'b0,
                  trap: 1'b0, tpc: 32'h0};
        end else if (!s.trap) begin
            if (rd) begin
                n.ipc = 32'h0; n.instr = NOP_INSTR; n.valid = 1'b0;
                if (rpc[1:0] == 2'b00) n.pc = rpc;
                else begin n.trap = 1'b1; n.tpc = rpc; end
            end else if (!st) begin
                n.ipc = s.pc; n.instr = imem_word(s.pc); n.valid = 1'b1;
                n.pc = s.pc + 32'd4;
            end
        end else begin
            n.ipc = 32'h0; n.instr = NOP_INSTR; n.valid = 1'b0;
            if (rd) begin
                if (rpc[1:0] == 2'b00) begin n.pc = rpc; n.trap = 1'b0; end
                else n.tpc = rpc;
            end
        end
        return n;
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), predict,
    // let the rising edge happen, then compare at the next falling edge.
    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        exp_t e;
        rst = r; stall = st; redir = rd; redir_pc = rpc;
        m = model_next(m, r, st, rd, rpc);
        exp_q.push_back(m);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("imem_addr", imem_addr, e.pc);
            check("if_id_pc", if_id_pc, e.ipc);
            check("if_id_pc4", if_id_pc4, e.ipc + 32'd4);
            check("if_id_instr", if_id_instr, e.instr);
            check("opcode", {25'd0, opcode}, {25'd0, e.instr[6:0]});
            check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            check("trap", {31'd0, trap}, {31'd0, e.trap});
            if (e.trap) check("trap_pc", trap_pc, e.tpc);
        end
    endtask

    task automatic run(input logic st);
        step(1'b0, st, 1'b0, 32'h0);
    endtask

    task automatic jump(input logic st, input logic [31:0] tgt);
        step(1'b0, st, 1'b1, tgt);
    endtask

    initial begin
        m = '0;
        @(negedge clk);

        // Reset: pc=RESET_PC, bubble, opcode 0010011, pc4 reads 4.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("reset_opcode", {25'd0, opcode}, 32'h13);
        check("reset_pc4", if_id_pc4, 32'd4);
        check("reset_trap_pc", trap_pc, 32'h0);

        // Straight-line fetch; first word is 0x00500093.
        run(1'b0);
        check("first_instr", if_id_instr, 32'h0050_0093);
        run(1'b0);
        check("second_instr", if_id_instr, 32'h00A0_0113);

        // Stall three cycles at pc=8, then resume.
        repeat (3) run(1'b1);
        run(1'b0);
        run(1'b0);

        // Redirect with simultaneous stall: redirect wins.
        jump(1'b1, 32'h0000_0100);
        run(1'b0);
        check("redir_pc4", if_id_pc4, 32'h0000_0104);
        run(1'b0);

        // Misaligned target traps; stall toggling is ignored; re-target while trapped.
        jump(1'b0, 32'h0000_0102);
        run(1'b1);
        run(1'b0);
        run(1'b1);
        jump(1'b1, 32'h0000_0203);
        run(1'b0);
        jump(1'b0, 32'h0000_0200);
        check("trap_clear", {31'd0, trap}, 32'd0);
        run(1'b0);
        check("post_trap_pc", if_id_pc, 32'h0000_0200);

        // PC wrap at the top of the address space.
        jump(1'b0, 32'hFFFF_FFF8);
        run(1'b0);
        run(1'b0);
        check("wrap_pc4", if_id_pc4, 32'h0000_0000);
        run(1'b0);

        // Reset during trap, during stall, and together with a redirect.
        jump(1'b0, 32'h0000_0001);
        run(1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        run(1'b0);
        run(1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        run(1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        run(1'b0);

        // Random mix of stalls, redirects (some misaligned) and rare resets.
        for (int i = 0; i < 200; i++) begin
            logic        r, st, rd;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 39) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 5) == 0);
            tgt = {$urandom_range(0, 255), 2'b00} + 32'h0000_0000;
            if ($urandom_range(0, 2) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) tgt[31:16] = 16'($urandom);
            step(r, st, rd, tgt);
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Backstop: the clock is free-running, so this only fires if the run wedges.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1, "timeout");
    end

endmodule
